// File: rtl/vga_text_pkg.sv
// Shared constants and size helpers for the VGA text-mode renderer.
package vga_text_pkg;

  localparam logic [7:0] CHAR_NUL    = 8'h00;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_TERM   = 8'h7E;

  localparam logic [7:0] IDX_UPPER   = 8'd0;
  localparam logic [7:0] IDX_LOWER   = 8'd26;
  localparam logic [7:0] IDX_DIGIT   = 8'd52;
  localparam logic [7:0] IDX_EQ      = 8'd62;
  localparam logic [7:0] IDX_BAR     = 8'd63;
  localparam logic [7:0] IDX_DASH    = 8'd64;
  localparam logic [7:0] IDX_INVALID = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int calc_depth(input int cols, input int rows);
    return cols * rows;
  endfunction

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_ga_w(input int glyphs, input int cw, input int ch);
    return cnt_w(glyphs * cw * ch);
  endfunction

endpackage

// File: rtl/vga_char_index.sv
// Character code to glyph-ROM index lookup; codes without a glyph map to IDX_INVALID.
module vga_char_index
  import vga_text_pkg::*;
(
  input  logic [7:0] char_code,
  output logic [7:0] glyph_idx
);

  always_comb begin
    glyph_idx = IDX_INVALID;
    if (char_code >= 8'h41 && char_code <= 8'h5A)
      glyph_idx = char_code - 8'h41 + IDX_UPPER;
    else if (char_code >= 8'h61 && char_code <= 8'h7A)
      glyph_idx = char_code - 8'h61 + IDX_LOWER;
    else if (char_code >= 8'h30 && char_code <= 8'h39)
      glyph_idx = char_code - 8'h30 + IDX_DIGIT;
    else if (char_code == 8'h3D)
      glyph_idx = IDX_EQ;
    else if (char_code == 8'h7C)
      glyph_idx = IDX_BAR;
    else if (char_code == 8'h2D)
      glyph_idx = IDX_DASH;
  end

endmodule

// File: rtl/vga_text_engine.sv
// Text-mode renderer: scans a char/colour RAM in step with VGA timing, drives the glyph ROM
// and composes RGB with a blinking underline cursor; a clear engine wipes the RAM.
module vga_text_engine
  import vga_text_pkg::*;
#(
  parameter int                       COLOR_WIDTH  = 4,
  parameter int                       COLS         = 80,
  parameter int                       ROWS         = 30,
  parameter int                       CHAR_W       = 6,
  parameter int                       CHAR_H       = 8,
  parameter int                       SCALE        = 1,
  parameter int                       NUM_GLYPHS   = 65,
  parameter logic [3*COLOR_WIDTH-1:0] BG_COLOR     = '0,
  parameter logic [7:0]               TERM_CHAR    = CHAR_TERM,
  parameter int                       BLINK_FRAMES = 30,
  localparam int                      DEPTH        = calc_depth(COLS, ROWS),
  localparam int                      AW           = cnt_w(DEPTH),
  localparam int                      GA_W         = calc_ga_w(NUM_GLYPHS, CHAR_W, CHAR_H),
  localparam int                      RGB_W        = 3 * COLOR_WIDTH
) (
  input  logic             iVGA_CLK,
  input  logic             iRST,
  input  logic             enable,
  input  logic             cHS,
  input  logic             cVS,
  input  logic             clr,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_char,
  input  logic [RGB_W-1:0] wr_color,
  input  logic             cursor_en,
  input  logic [AW-1:0]    cursor_pos,
  output logic [GA_W-1:0]  glyph_addr,
  input  logic             glyph_bit,
  output logic [RGB_W-1:0] RGB_out
);

  localparam int RAM_W   = 8 + RGB_W;
  localparam int CELL_PX = CHAR_W * SCALE;
  localparam int CELL_PY = CHAR_H * SCALE;
  localparam int PX_MAX  = COLS * CELL_PX - 1;
  localparam int PY_MAX  = ROWS * CELL_PY - 1;
  localparam int PX_W    = cnt_w(PX_MAX + 1);
  localparam int PY_W    = cnt_w(PY_MAX + 1);
  localparam int GX_W    = cnt_w(CHAR_W);
  localparam int GY_W    = cnt_w(CHAR_H);
  localparam int BC_W    = cnt_w(BLINK_FRAMES);

  logic [PX_W-1:0]  px;
  logic [PY_W-1:0]  py;
  logic             frame_restart;
  logic             restart_d;
  logic [BC_W-1:0]  blink_cnt;
  logic             blink_phase;

  logic [AW-1:0]    scan_cell;
  logic [GX_W-1:0]  scan_gx;
  logic [GY_W-1:0]  scan_gy;
  logic             cursor_hit;

  clr_state_t       state, state_nxt;
  logic [AW-1:0]    clr_ptr, clr_ptr_nxt;

  logic [RAM_W-1:0] ram [DEPTH];
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [RAM_W-1:0] ram_wdata;

  logic             vld_p0, vld_p1, vld_p2;
  logic [RAM_W-1:0] ram_q_p0;
  logic [GX_W-1:0]  gx_p0;
  logic [GY_W-1:0]  gy_p0;
  logic             hit_p0, hit_p1, hit_p2;
  logic [7:0]       char_p0;
  logic [7:0]       glyph_idx;
  logic             blank_p0, blank_p1, blank_p2;
  logic [RGB_W-1:0] color_p1, color_p2;

  assign frame_restart = ~cHS & ~cVS;

  // Scan position and cursor blink timebase
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      px          <= '0;
      py          <= '0;
      restart_d   <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      restart_d <= frame_restart;
      if (frame_restart) begin
        px <= '0;
        py <= '0;
      end else if (enable) begin
        if (px == PX_W'(PX_MAX)) begin
          px <= '0;
          py <= (py == PY_W'(PY_MAX)) ? '0 : py + 1'b1;
        end else begin
          px <= px + 1'b1;
        end
      end
      if (frame_restart && !restart_d) begin
        if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    scan_cell  = AW'((int'(px) / CELL_PX) + COLS * (int'(py) / CELL_PY));
    scan_gx    = GX_W'((int'(px) / SCALE) % CHAR_W);
    scan_gy    = GY_W'((int'(py) / SCALE) % CHAR_H);
    cursor_hit = cursor_en && blink_phase && (scan_cell == cursor_pos) &&
                 (scan_gy == GY_W'(CHAR_H - 1));
  end

  // Clear engine
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt   = ST_CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_ptr == AW'(DEPTH - 1)) begin
          state_nxt   = ST_IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

  // The clear engine owns the write port; host writes only land while idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = {wr_char, wr_color};
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = {CHAR_NUL, BG_COLOR};
    end else if (wr_en && !iRST && (int'(wr_addr) < DEPTH)) begin
      ram_we = 1'b1;
    end
  end

  // Stage p0: read-first RAM access, glyph coordinates and cursor hit travel alongside
  always_ff @(posedge iVGA_CLK) begin
    if (ram_we)
      ram[ram_waddr] <= ram_wdata;
    ram_q_p0 <= ram[scan_cell];
  end

  assign char_p0 = ram_q_p0[RAM_W-1 -: 8];

  vga_char_index u_char_index (
    .char_code (char_p0),
    .glyph_idx (glyph_idx)
  );

  assign blank_p0 = (char_p0 == CHAR_NUL) || (char_p0 == CHAR_SPACE) ||
                    (char_p0 == TERM_CHAR) || (glyph_idx == IDX_INVALID);

  always_ff @(posedge iVGA_CLK) begin
    gx_p0    <= scan_gx;
    gy_p0    <= scan_gy;
    hit_p0   <= cursor_hit;
    // Stage p1: glyph address issued, cell attributes wait for the ROM
    color_p1 <= ram_q_p0[RGB_W-1:0];
    blank_p1 <= blank_p0;
    hit_p1   <= hit_p0;
    // Stage p2: aligned with the ROM output bit
    color_p2 <= color_p1;
    blank_p2 <= blank_p1;
    hit_p2   <= hit_p1;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      glyph_addr <= '0;
      RGB_out    <= BG_COLOR;
    end else begin
      vld_p0 <= enable;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (glyph_idx == IDX_INVALID)
        glyph_addr <= '0;
      else
        glyph_addr <= GA_W'(int'(glyph_idx) * CHAR_W * CHAR_H +
                            int'(gy_p0) * CHAR_W + int'(gx_p0));
      // Output: cursor underline wins, blank cells and clear glyph bits show background
      if (!vld_p2)
        RGB_out <= BG_COLOR;
      else if (hit_p2)
        RGB_out <= ~BG_COLOR;
      else if (blank_p2 || !glyph_bit)
        RGB_out <= BG_COLOR;
      else
        RGB_out <= color_p2;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine: a 16x7 unscaled instance and a 4x2 instance at SCALE=2.
module tb_vga_text_engine;

  localparam logic [11:0] BG1    = 12'h012;
  localparam logic [11:0] BG2    = 12'h000;
  localparam int          LINE1  = 96;
  localparam int          LINE2  = 48;
  localparam int          DEPTH1 = 112;
  localparam int          CUR_N  = 7 * LINE1 + 30;

  typedef struct {
    bit          sel;
    int          px;
    int          py;
    logic [11:0] addr;
    logic [11:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, enable, chs, cvs, clr, wr_en1, wr_en2, cursor_en;
  logic [6:0]  wr_addr, cursor_pos;
  logic [2:0]  cursor_pos2;
  logic [7:0]  wr_char;
  logic [11:0] wr_color;
  logic        busy1, busy2, gbit1, gbit2;
  logic [11:0] gaddr1, gaddr2, rgb1, rgb2;

  int   checks = 0;
  int   errors = 0;
  int   rgb_bad;
  vec_t vec [24];
  int   nvec;

  always #5 clk = ~clk;

  vga_text_engine #(
    .COLOR_WIDTH(4), .COLS(16), .ROWS(7), .CHAR_W(6), .CHAR_H(8), .SCALE(1),
    .NUM_GLYPHS(65), .BG_COLOR(BG1), .TERM_CHAR(8'h7E), .BLINK_FRAMES(2)
  ) dut1 (
    .iVGA_CLK(clk), .iRST(rst), .enable(enable), .cHS(chs), .cVS(cvs), .clr(clr),
    .busy(busy1), .wr_en(wr_en1), .wr_addr(wr_addr), .wr_char(wr_char),
    .wr_color(wr_color), .cursor_en(cursor_en), .cursor_pos(cursor_pos),
    .glyph_addr(gaddr1), .glyph_bit(gbit1), .RGB_out(rgb1)
  );

  vga_text_engine #(
    .COLOR_WIDTH(4), .COLS(4), .ROWS(2), .CHAR_W(6), .CHAR_H(8), .SCALE(2),
    .NUM_GLYPHS(65), .BG_COLOR(BG2), .TERM_CHAR(8'h7E), .BLINK_FRAMES(30)
  ) dut2 (
    .iVGA_CLK(clk), .iRST(rst), .enable(enable), .cHS(chs), .cVS(cvs), .clr(clr),
    .busy(busy2), .wr_en(wr_en2), .wr_addr(wr_addr[2:0]), .wr_char(wr_char),
    .wr_color(wr_color), .cursor_en(cursor_en), .cursor_pos(cursor_pos2),
    .glyph_addr(gaddr2), .glyph_bit(gbit2), .RGB_out(rgb2)
  );

  // Glyph ROM model: one-cycle synchronous read, bit set when address is a multiple of 3.
  function automatic logic rom_fn(input logic [11:0] a);
    return (a % 12'd3) == 12'd0;
  endfunction

  always @(posedge clk) begin
    gbit1 <= rom_fn(gaddr1);
    gbit2 <= rom_fn(gaddr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit sel, input int a, input logic [7:0] c, input logic [11:0] col);
    wr_addr  = 7'(a);
    wr_char  = c;
    wr_color = col;
    wr_en1   = !sel;
    wr_en2   = sel;
    step(1);
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  // Counts samples with busy1 high, bounded; also flags any non-background pixel meanwhile.
  task automatic count_busy(output int cnt);
    cnt     = 0;
    rgb_bad = 0;
    while (busy1 && cnt < 1000) begin
      if (rgb1 !== BG1) rgb_bad++;
      cnt++;
      step(1);
    end
  endtask

  // Frame restart, then enable for pixels 0..n; checks the glyph address and colour of pixel n.
  task automatic render_check(input string name, input bit sel, input int n,
                              input logic [11:0] exp_addr, input logic [11:0] exp_rgb);
    chs = 1'b0; cvs = 1'b0; enable = 1'b0;
    step(1);
    chs = 1'b1; cvs = 1'b1; enable = 1'b1;
    step(n + 1);
    enable = 1'b0;
    step(1);
    check({name, "_addr"}, sel ? gaddr2 : gaddr1, exp_addr);
    step(2);
    check({name, "_rgb"}, sel ? rgb2 : rgb1, exp_rgb);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [11:0] exp_c;

    vec[0]  = '{1'b0,  0,  0, 12'h000, 12'hF00};
    vec[1]  = '{1'b0,  1,  0, 12'h001, BG1};
    vec[2]  = '{1'b0,  3,  1, 12'h009, 12'hF00};
    vec[3]  = '{1'b0,  6,  0, 12'h000, BG1};
    vec[4]  = '{1'b0, 12,  0, 12'h000, BG1};
    vec[5]  = '{1'b0, 20,  3, 12'h000, BG1};
    vec[6]  = '{1'b0, 24,  2, 12'h99C, 12'h0AA};
    vec[7]  = '{1'b0, 25,  2, 12'h99D, BG1};
    vec[8]  = '{1'b0, 39,  5, 12'hAD1, 12'h5A5};
    vec[9]  = '{1'b0, 42,  7, 12'hBCA, 12'h123};
    vec[10] = '{1'b0, 51,  0, 12'hBD3, 12'h456};
    vec[11] = '{1'b0, 54,  6, 12'hC24, 12'h789};
    vec[12] = '{1'b0, 60,  0, 12'h000, BG1};
    vec[13] = '{1'b0, 66,  0, 12'h4B0, 12'hF0F};
    vec[14] = '{1'b0, 72,  0, 12'h000, BG1};
    vec[15] = '{1'b0,  0, 10, 12'h4EC, 12'h0F0};
    vec[16] = '{1'b1,  0,  0, 12'h030, 12'h0FF};
    vec[17] = '{1'b1,  1,  0, 12'h030, 12'h0FF};
    vec[18] = '{1'b1,  2,  0, 12'h031, BG2};
    vec[19] = '{1'b1,  0,  1, 12'h030, 12'h0FF};
    vec[20] = '{1'b1,  6,  3, 12'h039, 12'h0FF};
    vec[21] = '{1'b1,  3,  3, 12'h037, BG2};
    vec[22] = '{1'b1, 11,  0, 12'h035, BG2};
    vec[23] = '{1'b1, 12,  2, 12'h066, 12'hF0F};
    nvec = 24;

    rst = 1'b1; enable = 1'b0; chs = 1'b1; cvs = 1'b1; clr = 1'b0;
    wr_en1 = 1'b0; wr_en2 = 1'b0; cursor_en = 1'b0;
    wr_addr = '0; wr_char = '0; wr_color = '0; cursor_pos = 7'd5; cursor_pos2 = 3'd7;
    step(2);
    check("rst_rgb1", rgb1, BG1);
    check("rst_rgb2", rgb2, BG2);
    check("rst_gaddr", gaddr1, 12'h000);
    check("rst_busy", busy1, 1'b1);
    rst = 1'b0;
    count_busy(cnt);
    check("init_clear_len", cnt, DEPTH1);
    check("init_clear_rgb_bad", rgb_bad, 0);
    check("init_busy2_done", busy2, 1'b0);

    wr(0, 0, 8'h41, 12'hF00);  wr(0, 1, 8'h20, 12'h0F0);
    wr(0, 2, 8'h7E, 12'h00F);  wr(0, 3, 8'h23, 12'hFFF);
    wr(0, 4, 8'h7A, 12'h0AA);  wr(0, 6, 8'h35, 12'h5A5);
    wr(0, 7, 8'h3D, 12'h123);  wr(0, 8, 8'h7C, 12'h456);
    wr(0, 9, 8'h2D, 12'h789);  wr(0, 10, 8'h00, 12'hABC);
    wr(0, 11, 8'h5A, 12'hF0F); wr(0, 12, 8'h40, 12'hFFF);
    wr(0, 16, 8'h61, 12'h0F0);
    wr(1, 0, 8'h42, 12'h0FF);  wr(1, 1, 8'h43, 12'hF0F);

    for (int i = 0; i < nvec; i++)
      render_check($sformatf("vec%0d", i), vec[i].sel,
                   vec[i].py * (vec[i].sel ? LINE2 : LINE1) + vec[i].px,
                   vec[i].addr, vec[i].rgb);

    // Clear with a host write attempted mid-clear, then an out-of-range write.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    cnt = 0;
    while (busy1 && cnt < 1000) begin
      if (cnt == 50) begin
        wr_en1 = 1'b1; wr_addr = 7'd3; wr_char = 8'h41; wr_color = 12'hF00;
      end else begin
        wr_en1 = 1'b0;
      end
      cnt++;
      step(1);
    end
    wr_en1 = 1'b0;
    check("clr_len", cnt, DEPTH1);
    wr(0, DEPTH1, 8'h41, 12'hF00);
    render_check("cleared_cell0", 0, 0, 12'h000, BG1);
    render_check("blocked_wr_cell3", 0, 18, 12'h000, BG1);
    render_check("cleared_cell4", 0, 2 * LINE1 + 24, 12'h000, BG1);

    // Write and scan read of cell 0 on the same edge: old contents are rendered.
    chs = 1'b0; cvs = 1'b0;
    step(1);
    chs = 1'b1; cvs = 1'b1; enable = 1'b1;
    wr_addr = 7'd0; wr_char = 8'h41; wr_color = 12'hF00; wr_en1 = 1'b1;
    step(1);
    enable = 1'b0; wr_en1 = 1'b0;
    step(3);
    check("rw_old_data", rgb1, BG1);
    render_check("rw_new_data", 0, 0, 12'h000, 12'hF00);

    // Reset while the clear pointer sits at 100.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_busy", busy1, 1'b1);
    count_busy(cnt);
    check("mid_rst_clear_len", cnt, DEPTH1);

    // Cursor blink with BLINK_FRAMES=2: underline shows in frames 2,3,6,7.
    cursor_en = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      exp_c = (f == 2 || f == 3 || f == 6 || f == 7) ? ~BG1 : BG1;
      render_check($sformatf("cursor_f%0d", f), 0, CUR_N, 12'h000, exp_c);
    end
    cursor_en = 1'b0;
    render_check("cursor_off_f10", 0, CUR_N, 12'h000, BG1);
    cursor_en = 1'b1;
    render_check("cursor_row6_f11", 0, CUR_N - LINE1, 12'h000, BG1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
